alu_param: RTL and testbench
============================

ALU_PARAM -- requirements
Module: alu_param

Interface
REQ-001 Parameters, one per line (name, default, meaning); the block SHALL provide:
- DATA_W, 8, datapath width in bits (>= 4).
- RF_DEPTH, 4, register-file entries, power of two >= 2; AW = clog2(RF_DEPTH).
REQ-002 Ports, one per line (name  direction  width  meaning):
- i_clk  in  1  single clock, all state on rising edge.
- i_rst  in  1  synchronous, active-high reset.
- i_valid  in  1  operation request.
- o_ready  out  1  block idle, request accepted when i_valid && o_ready.
- i_operation_code  in  4  opcode (REQ-006).
- i_direct_load  in  1  load i_direct_data instead of executing opcode.
- i_direct_data  in  DATA_W  immediate operand.
- i_data_memory_read_enable  in  1  1: operand = i_data_memory, 0: operand = RF read port.
- i_data_memory  in  DATA_W  data-memory operand.
- i_rf_wr_en  in  1  write accumulator into RF.
- i_rf_wr_addr  in  AW  RF write address.
- i_rf_rd_addr  in  AW  RF read address.
- o_alu  out  DATA_W  combinational single-cycle result.
- o_acumulator  out  DATA_W  accumulator.
- o_register_file  out  DATA_W  RF[i_rf_rd_addr], combinational read.
- o_carry  out  1  registered carry/borrow/overflow flag.
- o_zero  out  1  registered, 1 when accumulator == 0.
- o_done  out  1  one-cycle completion pulse.

Function
REQ-003 FSM states IDLE, MUL; o_ready = 1 only in IDLE; i_valid outside IDLE SHALL be ignored.
REQ-004 Single-cycle accept at edge k: accumulator, o_carry, o_zero updated at edge k; o_done high for the one cycle after edge k; FSM stays IDLE.
REQ-005 i_direct_load has priority over opcode: accumulator <= i_direct_data, o_carry <= 0.
REQ-006 Opcodes (A = accumulator, B = operand): 0000 ADD A+B, carry = bit DATA_W; 0001 SUB A-B, carry = borrow (A<B); 0010 AND; 0011 OR; 0100 XOR; 0101 NOT ~B; 0110 LD B; 0111 ADC A+B+o_carry; 1000 SHL A<<1, carry = old A msb; 1001 SHR A>>1 logical, carry = old A lsb; 1010 MUL; others NOP.
REQ-007 AND/OR/XOR/NOT/LD SHALL clear o_carry; NOP SHALL leave A and flags unchanged but still pulse o_done.
REQ-008 All arithmetic modulo 2^DATA_W; o_alu SHALL show the result for current A, B, opcode every cycle (0 for MUL/NOP).
REQ-009 MUL accept at edge k: A and B captured, FSM -> MUL; one shift-add step per edge for DATA_W steps; at edge k+DATA_W, A <= low DATA_W product bits, o_carry <= OR of high DATA_W bits, o_zero updated, FSM -> IDLE; o_done high the cycle after edge k+DATA_W.
REQ-010 Operand changes during MUL SHALL not affect the product.
REQ-011 RF write: at any edge with i_rf_wr_en, RF[i_rf_wr_addr] <= registered A (pre-update value, also during MUL); read of the same address in that cycle returns the old value.
REQ-012 o_zero SHALL track every accumulator write, including direct load.

Reset
REQ-013 i_rst at an edge SHALL set A, all RF entries, o_carry, o_done to 0, o_zero to 1, FSM to IDLE; i_rst dominates all other inputs.
REQ-014 i_rst during MUL SHALL abort it with no o_done pulse and no accumulator update beyond reset.

Configuration
REQ-015 Macro ALU_PARAM_MUL_EN: defined -> MUL state and shift-add multiplier compiled in per REQ-009; undefined -> no MUL state, opcode 1010 behaves as NOP (REQ-007), o_ready tied 1.

Verification
REQ-016 DATA_W=8: direct load 0xF0, ADD with RF operand 0x20 -> A=0x10, o_carry=1, o_zero=0, o_done one cycle.
REQ-017 A=0x05, SUB B=0x05 -> A=0x00, o_zero=1, o_carry=0; then SUB B=0x01 -> A=0xFF, o_carry=1.
REQ-018 With ALU_PARAM_MUL_EN: A=0x12, MUL B=0x10 -> o_ready low 8 cycles, A=0x20, o_carry=1, o_done 1 cycle after; i_valid held high during busy ignored.
REQ-019 i_rst asserted 3 cycles into MUL -> A=0, o_zero=1, no o_done, o_ready=1 next cycle.
REQ-020 RF_DEPTH=8: write A=0x5A to addr 7 while reading addr 7 -> old value same cycle, 0x5A next cycle; ADC after SHL of 0x80 -> carry-in 1 applied.

Source files
------------

// File: rtl/alu_param.sv
// alu_param: accumulator ALU with register file and optional shift-add
// multiplier (enabled by defining ALU_PARAM_MUL_EN).
// Ports:
//   i_clk, i_rst                  clock, synchronous active-high reset
//   i_valid / o_ready             request handshake
//   i_operation_code              4-bit opcode
//   i_direct_load, i_direct_data  immediate load into the accumulator
//   i_data_memory_read_enable     operand select (memory or RF)
//   i_data_memory                 memory operand
//   i_rf_wr_en/_addr, i_rf_rd_addr  register-file access
//   o_alu                         combinational result
//   o_acumulator, o_register_file accumulator and RF read data
//   o_carry, o_zero, o_done       registered flags and completion pulse
module alu_param #(
    parameter int  DATA_W   = 8,
    parameter int  RF_DEPTH = 4,
    localparam int AW       = $clog2(RF_DEPTH)
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic [3:0]        i_operation_code,
    input  logic              i_direct_load,
    input  logic [DATA_W-1:0] i_direct_data,
    input  logic              i_data_memory_read_enable,
    input  logic [DATA_W-1:0] i_data_memory,
    input  logic              i_rf_wr_en,
    input  logic [AW-1:0]     i_rf_wr_addr,
    input  logic [AW-1:0]     i_rf_rd_addr,
    output logic [DATA_W-1:0] o_alu,
    output logic [DATA_W-1:0] o_acumulator,
    output logic [DATA_W-1:0] o_register_file,
    output logic              o_carry,
    output logic              o_zero,
    output logic              o_done
);

    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0001;
    localparam logic [3:0] OP_AND = 4'b0010;
    localparam logic [3:0] OP_OR  = 4'b0011;
    localparam logic [3:0] OP_XOR = 4'b0100;
    localparam logic [3:0] OP_NOT = 4'b0101;
    localparam logic [3:0] OP_LD  = 4'b0110;
    localparam logic [3:0] OP_ADC = 4'b0111;
    localparam logic [3:0] OP_SHL = 4'b1000;
    localparam logic [3:0] OP_SHR = 4'b1001;

    logic [DATA_W-1:0] acc_q, acc_d;
    logic              carry_q, carry_d;
    logic              zero_q, zero_d;
    logic              done_q, done_d;
    logic [DATA_W-1:0] rf_q [RF_DEPTH];

    logic [DATA_W-1:0] opnd;
    logic [DATA_W-1:0] alu_res;
    logic              alu_cy;
    logic              alu_wr;
    logic              accept;

`ifdef ALU_PARAM_MUL_EN
    localparam logic [3:0] OP_MUL = 4'b1010;
    localparam int         CW     = $clog2(DATA_W);
    localparam logic [CW-1:0] LAST = CW'(DATA_W - 1);

    typedef enum logic {S_IDLE, S_MUL} state_e;
    state_e state_q, state_d;

    logic [2*DATA_W-1:0] prod_q, prod_d;
    logic [2*DATA_W-1:0] mcand_q, mcand_d;
    logic [DATA_W-1:0]   mplier_q, mplier_d;
    logic [CW-1:0]       cnt_q, cnt_d;

    assign o_ready = (state_q == S_IDLE);
`else
    assign o_ready = 1'b1;
`endif

    assign accept = i_valid & o_ready;
    assign opnd   = i_data_memory_read_enable ? i_data_memory
                                              : rf_q[i_rf_rd_addr];

    // Result of the current opcode; alu_wr marks opcodes that write A.
    always_comb begin
        alu_res = '0;
        alu_cy  = 1'b0;
        alu_wr  = 1'b1;
        case (i_operation_code)
            OP_ADD: {alu_cy, alu_res} = {1'b0, acc_q} + {1'b0, opnd};
            OP_SUB: begin
                alu_res = acc_q - opnd;
                alu_cy  = (acc_q < opnd);
            end
            OP_AND: alu_res = acc_q & opnd;
            OP_OR:  alu_res = acc_q | opnd;
            OP_XOR: alu_res = acc_q ^ opnd;
            OP_NOT: alu_res = ~opnd;
            OP_LD:  alu_res = opnd;
            OP_ADC: {alu_cy, alu_res} = {1'b0, acc_q} + {1'b0, opnd}
                                      + {{DATA_W{1'b0}}, carry_q};
            OP_SHL: begin
                alu_res = acc_q << 1;
                alu_cy  = acc_q[DATA_W-1];
            end
            OP_SHR: begin
                alu_res = acc_q >> 1;
                alu_cy  = acc_q[0];
            end
            default: alu_wr = 1'b0;
        endcase
    end

    assign o_alu = alu_res;

    always_comb begin
        acc_d   = acc_q;
        carry_d = carry_q;
        done_d  = 1'b0;
`ifdef ALU_PARAM_MUL_EN
        state_d  = state_q;
        prod_d   = prod_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        cnt_d    = cnt_q;
`endif
        if (accept) begin
            done_d = 1'b1;
            if (i_direct_load) begin
                acc_d   = i_direct_data;
                carry_d = 1'b0;
            end else if (alu_wr) begin
                acc_d   = alu_res;
                carry_d = alu_cy;
            end
`ifdef ALU_PARAM_MUL_EN
            else if (i_operation_code == OP_MUL) begin
                done_d   = 1'b0;
                state_d  = S_MUL;
                prod_d   = '0;
                mcand_d  = {{DATA_W{1'b0}}, acc_q};
                mplier_d = opnd;
                cnt_d    = '0;
            end
`endif
        end
`ifdef ALU_PARAM_MUL_EN
        // One shift-add step per cycle on the captured operands.
        if (state_q == S_MUL) begin
            prod_d   = prod_q + (mplier_q[0] ? mcand_q : '0);
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + 1'b1;
            if (cnt_q == LAST) begin
                acc_d   = prod_d[DATA_W-1:0];
                carry_d = |prod_d[2*DATA_W-1:DATA_W];
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
        end
`endif
        zero_d = (acc_d == '0);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            acc_q   <= '0;
            carry_q <= 1'b0;
            zero_q  <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            acc_q   <= acc_d;
            carry_q <= carry_d;
            zero_q  <= zero_d;
            done_q  <= done_d;
        end
    end

`ifdef ALU_PARAM_MUL_EN
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q  <= S_IDLE;
            prod_q   <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            prod_q   <= prod_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
        end
    end
`endif

    // RF stores the accumulator value held before this edge.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i < RF_DEPTH; i++) begin
                rf_q[i] <= '0;
            end
        end else if (i_rf_wr_en) begin
            rf_q[i_rf_wr_addr] <= acc_q;
        end
    end

    assign o_acumulator    = acc_q;
    assign o_register_file = rf_q[i_rf_rd_addr];
    assign o_carry         = carry_q;
    assign o_zero          = zero_q;
    assign o_done          = done_q;

endmodule

// File: tb/tb_alu_param.sv
// tb_alu_param: self-checking bench for alu_param (DATA_W=8, RF_DEPTH=8).
// Multiplier scenarios are exercised when ALU_PARAM_MUL_EN is defined.
module tb_alu_param;

    localparam int W   = 8;
    localparam int D   = 8;
    localparam int AW  = 3;
    localparam int MOD = 256;
`ifdef ALU_PARAM_MUL_EN
    localparam bit MUL_EN = 1'b1;
`else
    localparam bit MUL_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          valid = 1'b0;
    logic          dl = 1'b0;
    logic          mem_en = 1'b0;
    logic          wr_en = 1'b0;
    logic [3:0]    op = 4'h0;
    logic [W-1:0]  ddata = '0;
    logic [W-1:0]  mem = '0;
    logic [AW-1:0] wa = '0;
    logic [AW-1:0] ra = '0;

    logic          ready;
    logic [W-1:0]  alu;
    logic [W-1:0]  acc;
    logic [W-1:0]  rfo;
    logic          carry;
    logic          zero;
    logic          done;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state
    int m_acc, m_carry, m_done, m_busy, m_prod;
    int m_rf [D];

    always #5 clk = ~clk;

    alu_param #(.DATA_W(W), .RF_DEPTH(D)) dut (
        .i_clk                     (clk),
        .i_rst                     (rst),
        .i_valid                   (valid),
        .o_ready                   (ready),
        .i_operation_code          (op),
        .i_direct_load             (dl),
        .i_direct_data             (ddata),
        .i_data_memory_read_enable (mem_en),
        .i_data_memory             (mem),
        .i_rf_wr_en                (wr_en),
        .i_rf_wr_addr              (wa),
        .i_rf_rd_addr              (ra),
        .o_alu                     (alu),
        .o_acumulator              (acc),
        .o_register_file           (rfo),
        .o_carry                   (carry),
        .o_zero                    (zero),
        .o_done                    (done)
    );

    function automatic void model_op(input int o, input int a, input int b,
                                     input int cin, output int res,
                                     output int cy, output int wr);
        res = 0;
        cy  = 0;
        wr  = 1;
        case (o)
            0: begin res = (a + b) % MOD; cy = int'((a + b) >= MOD); end
            1: begin res = (a - b + MOD) % MOD; cy = int'(a < b); end
            2: res = a & b;
            3: res = a | b;
            4: res = a ^ b;
            5: res = (MOD - 1) - b;
            6: res = b;
            7: begin
                res = (a + b + cin) % MOD;
                cy  = int'((a + b + cin) >= MOD);
            end
            8: begin res = (a * 2) % MOD; cy = a / (MOD / 2); end
            9: begin res = a / 2; cy = a % 2; end
            default: wr = 0;
        endcase
    endfunction

    function automatic int get_b();
        return mem_en ? int'(mem) : m_rf[ra];
    endfunction

    // Advance the model by one edge using the current inputs, then clock.
    task automatic tick();
        int b, r, c, w;
        b = get_b();
        if (rst) begin
            m_acc = 0; m_carry = 0; m_done = 0; m_busy = 0;
            foreach (m_rf[i]) m_rf[i] = 0;
        end else begin
            if (wr_en) m_rf[wa] = m_acc;
            m_done = 0;
            if (m_busy > 0) begin
                m_busy--;
                if (m_busy == 0) begin
                    m_acc   = m_prod % MOD;
                    m_carry = int'(m_prod >= MOD);
                    m_done  = 1;
                end
            end else if (valid) begin
                m_done = 1;
                if (dl) begin
                    m_acc = int'(ddata); m_carry = 0;
                end else if (MUL_EN && op == 4'd10) begin
                    m_busy = W; m_prod = m_acc * b; m_done = 0;
                end else begin
                    model_op(int'(op), m_acc, b, m_carry, r, c, w);
                    if (w != 0) begin m_acc = r; m_carry = c; end
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic load(input int v);
        valid = 1'b1; dl = 1'b1; ddata = W'(v); wr_en = 1'b0;
        tick();
        dl = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; valid = 1'b1; dl = 1'b1; ddata = 8'h77;
        tick(); tick();
        n_checks++; if (acc !== 8'h00) $display("FAIL rst_acc: got %h want 00", acc); else n_pass++;
        n_checks++; if (zero !== 1'b1) $display("FAIL rst_zero: got %b want 1", zero); else n_pass++;
        n_checks++; if (carry !== 1'b0) $display("FAIL rst_carry: got %b want 0", carry); else n_pass++;
        n_checks++; if (done !== 1'b0) $display("FAIL rst_done: got %b want 0", done); else n_pass++;
        n_checks++; if (ready !== 1'b1) $display("FAIL rst_ready: got %b want 1", ready); else n_pass++;
        for (int i = 0; i < D; i++) begin
            ra = AW'(i);
            tick();
            n_checks++; if (rfo !== 8'h00) $display("FAIL rst_rf%0d: got %h want 00", i, rfo); else n_pass++;
        end
        rst = 1'b0; valid = 1'b0; dl = 1'b0;
        tick();
    endtask

    task automatic test_add_sub();
        load(8'h20);
        valid = 1'b0; wr_en = 1'b1; wa = 3'd2;
        tick();
        wr_en = 1'b0;
        load(8'hF0);
        n_checks++; if (acc !== 8'hF0) $display("FAIL ld_acc: got %h want f0", acc); else n_pass++;
        n_checks++; if (done !== 1'b1) $display("FAIL ld_done: got %b want 1", done); else n_pass++;
        op = 4'h0; mem_en = 1'b0; ra = 3'd2; valid = 1'b1;
        #1;
        n_checks++; if (alu !== 8'h10) $display("FAIL add_alu: got %h want 10", alu); else n_pass++;
        tick();
        n_checks++; if (acc !== 8'h10) $display("FAIL add_acc: got %h want 10", acc); else n_pass++;
        n_checks++; if (carry !== 1'b1) $display("FAIL add_carry: got %b want 1", carry); else n_pass++;
        n_checks++; if (zero !== 1'b0) $display("FAIL add_zero: got %b want 0", zero); else n_pass++;
        n_checks++; if (done !== 1'b1) $display("FAIL add_done: got %b want 1", done); else n_pass++;
        valid = 1'b0;
        tick();
        n_checks++; if (done !== 1'b0) $display("FAIL add_done_off: got %b want 0", done); else n_pass++;
        load(8'h05);
        op = 4'h1; mem_en = 1'b1; mem = 8'h05; valid = 1'b1;
        tick();
        n_checks++; if (acc !== 8'h00) $display("FAIL sub0_acc: got %h want 00", acc); else n_pass++;
        n_checks++; if (zero !== 1'b1) $display("FAIL sub0_zero: got %b want 1", zero); else n_pass++;
        n_checks++; if (carry !== 1'b0) $display("FAIL sub0_carry: got %b want 0", carry); else n_pass++;
        mem = 8'h01;
        tick();
        n_checks++; if (acc !== 8'hFF) $display("FAIL sub1_acc: got %h want ff", acc); else n_pass++;
        n_checks++; if (carry !== 1'b1) $display("FAIL sub1_carry: got %b want 1", carry); else n_pass++;
        valid = 1'b0; mem_en = 1'b0;
        tick();
    endtask

    task automatic test_rf_shift_adc();
        load(8'h5A);
        valid = 1'b0; wr_en = 1'b1; wa = 3'd7; ra = 3'd7;
        #1;
        n_checks++; if (rfo !== 8'h00) $display("FAIL rf_old: got %h want 00", rfo); else n_pass++;
        tick();
        wr_en = 1'b0;
        n_checks++; if (rfo !== 8'h5A) $display("FAIL rf_new: got %h want 5a", rfo); else n_pass++;
        load(8'h80);
        op = 4'h8; valid = 1'b1;
        tick();
        n_checks++; if (acc !== 8'h00) $display("FAIL shl_acc: got %h want 00", acc); else n_pass++;
        n_checks++; if (carry !== 1'b1) $display("FAIL shl_carry: got %b want 1", carry); else n_pass++;
        op = 4'h7; mem_en = 1'b1; mem = 8'h03;
        tick();
        n_checks++; if (acc !== 8'h04) $display("FAIL adc_acc: got %h want 04", acc); else n_pass++;
        n_checks++; if (carry !== 1'b0) $display("FAIL adc_carry: got %b want 0", carry); else n_pass++;
        valid = 1'b0; mem_en = 1'b0;
        tick();
    endtask

    task automatic test_nop_logic();
        load(8'h81);
        op = 4'h8; valid = 1'b1;
        tick();
        op = 4'hF;
        #1;
        n_checks++; if (alu !== 8'h00) $display("FAIL nop_alu: got %h want 00", alu); else n_pass++;
        tick();
        n_checks++; if (acc !== 8'h02) $display("FAIL nop_acc: got %h want 02", acc); else n_pass++;
        n_checks++; if (carry !== 1'b1) $display("FAIL nop_carry: got %b want 1", carry); else n_pass++;
        n_checks++; if (done !== 1'b1) $display("FAIL nop_done: got %b want 1", done); else n_pass++;
`ifndef ALU_PARAM_MUL_EN
        op = 4'hA;
        tick();
        n_checks++; if (acc !== 8'h02) $display("FAIL op10_acc: got %h want 02", acc); else n_pass++;
        n_checks++; if (done !== 1'b1) $display("FAIL op10_done: got %b want 1", done); else n_pass++;
`endif
        op = 4'h2; mem_en = 1'b1; mem = 8'hFF;
        tick();
        n_checks++; if (carry !== 1'b0) $display("FAIL and_carry: got %b want 0", carry); else n_pass++;
        n_checks++; if (acc !== 8'h02) $display("FAIL and_acc: got %h want 02", acc); else n_pass++;
        valid = 1'b0; mem_en = 1'b0;
        tick();
    endtask

`ifdef ALU_PARAM_MUL_EN
    task automatic test_mul();
        load(8'h12);
        op = 4'hA; mem_en = 1'b1; mem = 8'h10; valid = 1'b1;
        tick();
        op = 4'h0;
        for (int i = 0; i < W; i++) begin
            mem = W'($urandom);
            #1;
            n_checks++; if (ready !== 1'b0) $display("FAIL mul_busy%0d: got %b want 0", i, ready); else n_pass++;
            n_checks++; if (done !== 1'b0) $display("FAIL mul_early_done%0d: got %b want 0", i, done); else n_pass++;
            tick();
        end
        valid = 1'b0;
        n_checks++; if (acc !== 8'h20) $display("FAIL mul_acc: got %h want 20", acc); else n_pass++;
        n_checks++; if (carry !== 1'b1) $display("FAIL mul_carry: got %b want 1", carry); else n_pass++;
        n_checks++; if (done !== 1'b1) $display("FAIL mul_done: got %b want 1", done); else n_pass++;
        n_checks++; if (ready !== 1'b1) $display("FAIL mul_ready: got %b want 1", ready); else n_pass++;
        tick();
        n_checks++; if (done !== 1'b0) $display("FAIL mul_done_off: got %b want 0", done); else n_pass++;
        load(8'h33);
        op = 4'hA; mem = 8'h03; valid = 1'b1;
        tick();
        valid = 1'b0;
        tick(); tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_checks++; if (acc !== 8'h00) $display("FAIL abort_acc: got %h want 00", acc); else n_pass++;
        n_checks++; if (zero !== 1'b1) $display("FAIL abort_zero: got %b want 1", zero); else n_pass++;
        n_checks++; if (ready !== 1'b1) $display("FAIL abort_ready: got %b want 1", ready); else n_pass++;
        for (int i = 0; i < W + 2; i++) begin
            tick();
            n_checks++; if (done !== 1'b0) $display("FAIL abort_done%0d: got %b want 0", i, done); else n_pass++;
        end
        mem_en = 1'b0;
    endtask
`endif

    task automatic test_random();
        int r, c, w, b, exp_alu;
        for (int n = 0; n < 400; n++) begin
            rst    = ($urandom_range(0, 49) == 0);
            valid  = ($urandom_range(0, 3) != 0);
            dl     = ($urandom_range(0, 4) == 0);
            op     = 4'($urandom);
            ddata  = W'($urandom);
            mem    = W'($urandom);
            mem_en = 1'($urandom);
            wr_en  = ($urandom_range(0, 2) == 0);
            wa     = AW'($urandom);
            ra     = AW'($urandom);
            #1;
            b = get_b();
            model_op(int'(op), m_acc, b, m_carry, r, c, w);
            exp_alu = (w != 0) ? r : 0;
            n_checks++; if (alu !== W'(exp_alu)) $display("FAIL rnd_alu%0d: got %h want %h", n, alu, W'(exp_alu)); else n_pass++;
            n_checks++; if (rfo !== W'(m_rf[ra])) $display("FAIL rnd_rf%0d: got %h want %h", n, rfo, W'(m_rf[ra])); else n_pass++;
            n_checks++; if (ready !== (m_busy == 0)) $display("FAIL rnd_ready%0d: got %b want %b", n, ready, m_busy == 0); else n_pass++;
            tick();
            n_checks++; if (acc !== W'(m_acc)) $display("FAIL rnd_acc%0d: got %h want %h", n, acc, W'(m_acc)); else n_pass++;
            n_checks++; if (carry !== 1'(m_carry)) $display("FAIL rnd_carry%0d: got %b want %b", n, carry, 1'(m_carry)); else n_pass++;
            n_checks++; if (zero !== (m_acc == 0)) $display("FAIL rnd_zero%0d: got %b want %b", n, zero, m_acc == 0); else n_pass++;
            n_checks++; if (done !== 1'(m_done)) $display("FAIL rnd_done%0d: got %b want %b", n, done, 1'(m_done)); else n_pass++;
        end
        rst = 1'b0; valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_add_sub();
        test_rf_shift_adc();
        test_nop_logic();
`ifdef ALU_PARAM_MUL_EN
        test_mul();
`endif
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
